qbus_wb_bridge: RTL and testbench



---
 rtl/qbus_wb_bridge_pkg.sv | 30 +++
 rtl/qbus_wb_bridge_clkgen.sv | 49 ++++
 rtl/qbus_wb_bridge.sv | 223 ++++++++++++++++++++++
 tb/tb_qbus_wb_bridge.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qbus_wb_bridge_pkg.sv
// Shared definitions for the Q-bus (MPI) slave to Wishbone master bridge.
package qbus_wb_bridge_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_RPLY,
    ST_WR_WAIT,
    ST_WR_REQ,
    ST_WR_RPLY,
    ST_IV_REQ,
    ST_SEL_RPLY,
    ST_ABORT
  } qbus_state_t;

  localparam logic [7:0] VM2_CLOCK_HIGH  = 8'd3;
  localparam logic [7:0] VM2_CLOCK_LOW   = 8'd7;
  localparam int         SYNC_STAGES_DEF = 2;

  localparam logic [1:0] SEL_WORD = 2'b11;
  localparam logic [1:0] SEL_LO   = 2'b01;
  localparam logic [1:0] SEL_HI   = 2'b10;

  // Byte strobes for a write: odd address selects the high lane.
  function automatic logic [1:0] lane_sel(input logic byte_xfer, input logic adr0);
    if (!byte_xfer) return SEL_WORD;
    return adr0 ? SEL_HI : SEL_LO;
  endfunction

endpackage

// File: rtl/qbus_wb_bridge_clkgen.sv
// CPU clock divider; power flags and interrupt requests are resampled on the
// divider rise point so the CPU sees them change only with its clock edge.
module qbus_wb_bridge_clkgen
  import qbus_wb_bridge_pkg::*;
#(
  parameter logic [7:0] DIV_HIGH = VM2_CLOCK_HIGH,
  parameter logic [7:0] DIV_LOW  = VM2_CLOCK_LOW,
  parameter int         NIRQ     = 3
) (
  input  logic            vm_clk_p,
  input  logic            vm_rst,
  input  logic            vm_aclo,
  input  logic            vm_dclo,
  input  logic [NIRQ-1:0] vm_irq,
  output logic            qbus_clk_o,
  output logic            qbus_aclo_o,
  output logic            qbus_dclo_o,
  output logic [NIRQ-1:0] qbus_irq_o
);

  logic [7:0] div_cnt;
  logic       at_high;
  logic       at_low;

  assign at_high = (div_cnt == DIV_HIGH);
  assign at_low  = (div_cnt == DIV_LOW);

  // Divider counter, clock output and resampled flags.
  always_ff @(posedge vm_clk_p) begin
    if (vm_rst) begin
      div_cnt     <= '0;
      qbus_clk_o  <= 1'b0;
      qbus_aclo_o <= 1'b0;
      qbus_dclo_o <= 1'b0;
      qbus_irq_o  <= '0;
    end else begin
      div_cnt <= at_low ? 8'd0 : div_cnt + 8'd1;
      if (at_high) begin
        qbus_clk_o  <= 1'b1;
        qbus_aclo_o <= vm_aclo;
        qbus_dclo_o <= vm_dclo;
        qbus_irq_o  <= vm_irq;
      end else if (at_low) begin
        qbus_clk_o  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/qbus_wb_bridge.sv
// Q-bus slave to Wishbone master bridge for an external 1801-series CPU.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | no data phase in progress (may be inside a SYNC cycle)
// ST_RD_REQ   | Wishbone read in flight
// ST_RD_RPLY  | read data driven on AD with RPLY, waiting for DIN low
// ST_WR_WAIT  | DOUT seen, letting write data settle
// ST_WR_REQ   | Wishbone write in flight
// ST_WR_RPLY  | write acknowledged with RPLY, waiting for DOUT low
// ST_IV_REQ   | interrupt vector fetch in flight
// ST_SEL_RPLY | addressless read of sel_dat_i driven with RPLY
// ST_ABORT    | failed cycle, no RPLY; waiting for DIN and DOUT low
module qbus_wb_bridge
  import qbus_wb_bridge_pkg::*;
#(
  parameter logic [7:0] DIV_HIGH    = VM2_CLOCK_HIGH,
  parameter logic [7:0] DIV_LOW     = VM2_CLOCK_LOW,
  parameter int         SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int         WR_DELAY    = 1,
  parameter int         TIMEOUT     = 255,
  parameter int         NIRQ        = 3
) (
  input  logic            vm_clk_p,
  input  logic            vm_rst,
  input  logic [15:0]     qbus_ad_i,
  output logic [15:0]     qbus_ad_o,
  output logic            qbus_ad_oe,
  input  logic            qbus_sync_i,
  input  logic            qbus_din_i,
  input  logic            qbus_dout_i,
  input  logic            qbus_wtbt_i,
  input  logic            qbus_iako_i,
  input  logic            qbus_sel_i,
  input  logic            qbus_init_i,
  output logic            qbus_rply_o,
  output logic            qbus_ar_o,
  output logic            qbus_clk_o,
  output logic            qbus_aclo_o,
  output logic            qbus_dclo_o,
  output logic [NIRQ-1:0] qbus_irq_o,
  input  logic            vm_aclo,
  input  logic            vm_dclo,
  input  logic [NIRQ-1:0] vm_irq,
  output logic            vm_init_out,
  input  logic [15:0]     sel_dat_i,
  output logic [15:0]     wbm_adr_o,
  output logic [15:0]     wbm_dat_o,
  input  logic [15:0]     wbm_dat_i,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [1:0]      wbm_sel_o,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i,
  input  logic [15:0]     wbi_dat_i,
  output logic            wbi_stb_o,
  input  logic            wbi_ack_i,
  output logic            bus_err_o
);

  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);
  localparam logic [7:0] WR_LAST = 8'(WR_DELAY - 1);

  logic [SYNC_STAGES-1:0][6:0] sync_pipe;
  logic sync_s, din_s, dout_s, wtbt_s, iako_s, sel_s, init_s;

  qbus_state_t state, state_nxt;
  logic [15:0] adr_q, dat_q, wr_dat_q;
  logic [1:0]  sel_q;
  logic [7:0]  tmo_cnt, wr_cnt;
  logic        bus_err_q;
  logic        ld_dat, ld_rd, ld_wr, err_nxt, tmo_hit, stb_any;
  logic [15:0] dat_src;

  // Input synchroniser for the raw Q-bus strobes.
  always_ff @(posedge vm_clk_p) begin
    if (vm_rst) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[SYNC_STAGES-2:0],
                              {qbus_init_i, qbus_sel_i, qbus_iako_i, qbus_wtbt_i,
                               qbus_dout_i, qbus_din_i, qbus_sync_i}};
  end

  assign {init_s, sel_s, iako_s, wtbt_s, dout_s, din_s, sync_s} = sync_pipe[SYNC_STAGES-1];

  // Counter reaches TIMEOUT on the edge that drops the strobes, so stb is
  // high for exactly TIMEOUT cycles.
  assign stb_any = wbm_stb_o | wbi_stb_o;
  assign tmo_hit = (tmo_cnt + 8'd1) == TMO_LIM;

  // State register.
  always_ff @(posedge vm_clk_p) begin
    if (vm_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath load decisions.
  always_comb begin
    state_nxt = state;
    ld_dat    = 1'b0;
    dat_src   = wbm_dat_i;
    ld_rd     = 1'b0;
    ld_wr     = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (din_s && dout_s) begin
          state_nxt = ST_IDLE;
        end else if (din_s && !sync_s && sel_s) begin
          state_nxt = ST_SEL_RPLY;
          ld_dat    = 1'b1;
          dat_src   = sel_dat_i;
        end else if (din_s && iako_s) begin
          state_nxt = ST_IV_REQ;
        end else if (sync_s && din_s) begin
          state_nxt = ST_RD_REQ;
          ld_rd     = 1'b1;
        end else if (sync_s && dout_s) begin
          state_nxt = ST_WR_WAIT;
        end
      end
      ST_RD_REQ, ST_WR_REQ: begin
        if (wbm_ack_i) begin
          state_nxt = (state == ST_RD_REQ) ? ST_RD_RPLY : ST_WR_RPLY;
          ld_dat    = (state == ST_RD_REQ);
        end else if (wbm_err_i || tmo_hit) begin
          state_nxt = ST_ABORT;
          err_nxt   = 1'b1;
        end else if (!sync_s) begin
          state_nxt = ST_ABORT;
        end
      end
      ST_IV_REQ: begin
        if (wbi_ack_i) begin
          state_nxt = ST_RD_RPLY;
          ld_dat    = 1'b1;
          dat_src   = wbi_dat_i;
        end else if (tmo_hit) begin
          state_nxt = ST_ABORT;
          err_nxt   = 1'b1;
        end
      end
      ST_RD_RPLY, ST_SEL_RPLY: begin
        if (!din_s) state_nxt = ST_IDLE;
      end
      ST_WR_WAIT: begin
        if (!dout_s) begin
          state_nxt = ST_IDLE;
        end else if (wr_cnt == WR_LAST) begin
          // Power going down: acknowledge the CPU but keep memory untouched.
          if (vm_dclo) begin
            state_nxt = ST_WR_RPLY;
          end else begin
            state_nxt = ST_WR_REQ;
            ld_wr     = 1'b1;
          end
        end
      end
      ST_WR_RPLY: begin
        if (!dout_s) state_nxt = ST_IDLE;
      end
      ST_ABORT: begin
        if (!din_s && !dout_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address latch, data registers, timers and error pulse.
  always_ff @(posedge vm_clk_p) begin
    if (vm_rst) begin
      adr_q     <= '0;
      dat_q     <= '0;
      wr_dat_q  <= '0;
      sel_q     <= '0;
      tmo_cnt   <= '0;
      wr_cnt    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (!sync_s) adr_q <= qbus_ad_i;
      if (ld_dat)  dat_q <= dat_src;
      if (ld_rd)   sel_q <= SEL_WORD;
      if (ld_wr) begin
        wr_dat_q <= qbus_ad_i;
        sel_q    <= lane_sel(wtbt_s, adr_q[0]);
      end
      tmo_cnt   <= stb_any ? tmo_cnt + 8'd1 : 8'd0;
      wr_cnt    <= (state == ST_WR_WAIT) ? wr_cnt + 8'd1 : 8'd0;
      bus_err_q <= err_nxt;
    end
  end

  assign wbm_stb_o   = (state == ST_RD_REQ) || (state == ST_WR_REQ);
  assign wbm_cyc_o   = wbm_stb_o;
  assign wbm_we_o    = (state == ST_WR_REQ);
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = wr_dat_q;
  assign wbi_stb_o   = (state == ST_IV_REQ);
  assign qbus_rply_o = (state == ST_RD_RPLY) || (state == ST_WR_RPLY) || (state == ST_SEL_RPLY);
  assign qbus_ad_oe  = (state == ST_RD_RPLY) || (state == ST_SEL_RPLY);
  assign qbus_ad_o   = dat_q;
  assign qbus_ar_o   = sync_s & ~qbus_rply_o & ~din_s & ~dout_s;
  assign bus_err_o   = bus_err_q;
  assign vm_init_out = init_s;

  qbus_wb_bridge_clkgen #(
    .DIV_HIGH (DIV_HIGH),
    .DIV_LOW  (DIV_LOW),
    .NIRQ     (NIRQ)
  ) u_clkgen (
    .vm_clk_p    (vm_clk_p),
    .vm_rst      (vm_rst),
    .vm_aclo     (vm_aclo),
    .vm_dclo     (vm_dclo),
    .vm_irq      (vm_irq),
    .qbus_clk_o  (qbus_clk_o),
    .qbus_aclo_o (qbus_aclo_o),
    .qbus_dclo_o (qbus_dclo_o),
    .qbus_irq_o  (qbus_irq_o)
  );

endmodule

// File: tb/tb_qbus_wb_bridge.sv
// Scoreboard bench: CPU-side tasks push expected Wishbone and RPLY events,
// independent responder/monitor processes pop and compare them.
module tb_qbus_wb_bridge;

  localparam int SS   = 2;
  localparam int TMO  = 15;
  localparam int NIRQ = 3;

  logic vm_clk_p, vm_rst;
  logic [15:0] qbus_ad_i, qbus_ad_o;
  logic qbus_ad_oe, qbus_sync_i, qbus_din_i, qbus_dout_i, qbus_wtbt_i;
  logic qbus_iako_i, qbus_sel_i, qbus_init_i, qbus_rply_o, qbus_ar_o;
  logic qbus_clk_o, qbus_aclo_o, qbus_dclo_o;
  logic [NIRQ-1:0] qbus_irq_o, vm_irq;
  logic vm_aclo, vm_dclo, vm_init_out;
  logic [15:0] sel_dat_i, wbm_adr_o, wbm_dat_o, wbm_dat_i, wbi_dat_i;
  logic wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i, wbm_err_i;
  logic [1:0] wbm_sel_o;
  logic wbi_stb_o, wbi_ack_i, bus_err_o;

  qbus_wb_bridge #(
    .DIV_HIGH(8'd3), .DIV_LOW(8'd7), .SYNC_STAGES(SS), .WR_DELAY(1),
    .TIMEOUT(TMO), .NIRQ(NIRQ)
  ) dut (
    .vm_clk_p(vm_clk_p), .vm_rst(vm_rst),
    .qbus_ad_i(qbus_ad_i), .qbus_ad_o(qbus_ad_o), .qbus_ad_oe(qbus_ad_oe),
    .qbus_sync_i(qbus_sync_i), .qbus_din_i(qbus_din_i), .qbus_dout_i(qbus_dout_i),
    .qbus_wtbt_i(qbus_wtbt_i), .qbus_iako_i(qbus_iako_i), .qbus_sel_i(qbus_sel_i),
    .qbus_init_i(qbus_init_i), .qbus_rply_o(qbus_rply_o), .qbus_ar_o(qbus_ar_o),
    .qbus_clk_o(qbus_clk_o), .qbus_aclo_o(qbus_aclo_o), .qbus_dclo_o(qbus_dclo_o),
    .qbus_irq_o(qbus_irq_o), .vm_aclo(vm_aclo), .vm_dclo(vm_dclo), .vm_irq(vm_irq),
    .vm_init_out(vm_init_out), .sel_dat_i(sel_dat_i),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .wbi_dat_i(wbi_dat_i), .wbi_stb_o(wbi_stb_o), .wbi_ack_i(wbi_ack_i),
    .bus_err_o(bus_err_o)
  );

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    int          lat;
    bit          noack;
  } wb_t;

  typedef struct {
    bit          rd;
    logic [15:0] dat;
    bit          chk_lat;
  } rp_t;

  wb_t         wb_q[$];
  rp_t         rp_q[$];
  logic [15:0] iv_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ack_cyc = 0;
  int berr_cyc = 0;
  int exp_berr = 0;

  initial begin
    vm_clk_p = 1'b0;
    forever #5 vm_clk_p = ~vm_clk_p;
  end

  always @(posedge vm_clk_p) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge vm_clk_p);
  endtask

  task automatic wait_rply(input logic v, input string nm);
    int n = 0;
    while (qbus_rply_o !== v && n < 200) begin
      @(negedge vm_clk_p);
      n++;
    end
    chk(nm, qbus_rply_o, v);
  endtask

  // Wishbone slave: compares each request against the model, then answers.
  initial begin
    wb_t t;
    int  n;
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_dat_i = '0;
    forever begin
      @(negedge vm_clk_p);
      if (wbm_stb_o === 1'b1 && wbm_cyc_o === 1'b1) begin
        if (wb_q.size() == 0) begin
          chk("wb_unexpected_stb", wbm_stb_o, 0);
          n = 0;
          while (wbm_stb_o === 1'b1 && n < 300) begin @(negedge vm_clk_p); n++; end
        end else begin
          t = wb_q.pop_front();
          chk("wb_we", wbm_we_o, t.we);
          chk("wb_adr", wbm_adr_o, t.adr);
          chk("wb_sel", wbm_sel_o, t.sel);
          if (t.we) chk("wb_wdat", wbm_dat_o, t.dat);
          if (t.noack) begin
            n = 1;
            while (wbm_stb_o === 1'b1 && n < 300) begin
              @(negedge vm_clk_p);
              if (wbm_stb_o === 1'b1) n++;
            end
            chk("tmo_stb_cycles", n, TMO);
          end else begin
            repeat (t.lat - 1) @(negedge vm_clk_p);
            wbm_dat_i = t.we ? 16'h0000 : t.dat;
            wbm_ack_i = 1'b1;
            ack_cyc   = cyc + 1;
            @(negedge vm_clk_p);
            wbm_ack_i = 1'b0;
          end
        end
      end
    end
  end

  // Interrupt vector responder.
  initial begin
    wbi_ack_i = 1'b0;
    wbi_dat_i = '0;
    forever begin
      @(negedge vm_clk_p);
      if (wbi_stb_o === 1'b1) begin
        if (iv_q.size() == 0) begin
          chk("wbi_unexpected_stb", wbi_stb_o, 0);
        end else begin
          wbi_dat_i = iv_q.pop_front();
          wbi_ack_i = 1'b1;
          ack_cyc   = cyc + 1;
          @(negedge vm_clk_p);
          wbi_ack_i = 1'b0;
          chk("wbi_stb_len", wbi_stb_o, 0);
        end
      end
    end
  end

  // RPLY monitor.
  initial begin
    logic prev = 1'b0;
    rp_t  e;
    forever begin
      @(negedge vm_clk_p);
      if (qbus_rply_o === 1'b1 && prev !== 1'b1) begin
        if (rp_q.size() == 0) begin
          chk("rply_unexpected", qbus_rply_o, 0);
        end else begin
          e = rp_q.pop_front();
          chk("rply_ad_oe", qbus_ad_oe, e.rd);
          if (e.rd) chk("rply_data", qbus_ad_o, e.dat);
          if (e.chk_lat) chk("rply_after_ack", cyc, ack_cyc);
        end
      end
      prev = qbus_rply_o;
    end
  end

  always @(negedge vm_clk_p) if (bus_err_o === 1'b1) berr_cyc++;

  task automatic addr_phase(input logic [15:0] adr, input logic byt);
    qbus_ad_i   = adr;
    qbus_wtbt_i = byt;
    qbus_sync_i = 1'b0;
    tick(2);
    qbus_sync_i = 1'b1;
    tick(SS + 2);
    chk("ar_addr_phase", qbus_ar_o, 1);
    qbus_ad_i = 16'($urandom);
  endtask

  task automatic end_cycle();
    qbus_sync_i = 1'b0;
    qbus_wtbt_i = 1'b0;
    tick(3);
  endtask

  task automatic do_read(input logic [15:0] adr, input logic [15:0] dat,
                         input int lat, input bit timing);
    wb_q.push_back('{we: 1'b0, adr: adr, dat: dat, sel: 2'b11, lat: lat, noack: 1'b0});
    rp_q.push_back('{rd: 1'b1, dat: dat, chk_lat: 1'b1});
    qbus_din_i = 1'b1;
    if (timing) begin
      tick(SS);
      chk("stb_early", wbm_stb_o, 0);
      tick(1);
      chk("stb_latency", wbm_stb_o, 1);
    end
    wait_rply(1'b1, "rd_rply_wait");
    chk("ar_in_rply", qbus_ar_o, 0);
    tick(1);
    qbus_din_i = 1'b0;
    tick(SS);
    chk("rd_rply_hold", qbus_rply_o, 1);
    tick(1);
    chk("rd_rply_drop", qbus_rply_o, 0);
    chk("rd_oe_drop", qbus_ad_oe, 0);
  endtask

  task automatic do_write(input logic [15:0] adr, input logic [15:0] dat, input logic byt,
                          input bit suppress, input int lat);
    logic [1:0] s;
    s = !byt ? 2'b11 : (adr[0] ? 2'b10 : 2'b01);
    if (!suppress)
      wb_q.push_back('{we: 1'b1, adr: adr, dat: dat, sel: s, lat: lat, noack: 1'b0});
    rp_q.push_back('{rd: 1'b0, dat: 16'h0, chk_lat: !suppress});
    qbus_ad_i   = dat;
    qbus_dout_i = 1'b1;
    wait_rply(1'b1, "wr_rply_wait");
    tick(1);
    qbus_dout_i = 1'b0;
    wait_rply(1'b0, "wr_rply_release");
  endtask

  task automatic addrless_read(input bit iv, input logic [15:0] dat);
    qbus_sync_i = 1'b0;
    if (iv) begin
      iv_q.push_back(dat);
      qbus_iako_i = 1'b1;
    end else begin
      sel_dat_i  = dat;
      qbus_sel_i = 1'b1;
    end
    rp_q.push_back('{rd: 1'b1, dat: dat, chk_lat: iv});
    qbus_din_i = 1'b1;
    wait_rply(1'b1, iv ? "iv_rply_wait" : "sel_rply_wait");
    tick(1);
    qbus_din_i = 1'b0;
    wait_rply(1'b0, "addrless_release");
    qbus_iako_i = 1'b0;
    qbus_sel_i  = 1'b0;
    tick(2);
  endtask

  task automatic wait_clk_rise();
    logic p;
    int   n = 0;
    p = qbus_clk_o;
    @(negedge vm_clk_p);
    while (!(qbus_clk_o === 1'b1 && p === 1'b0) && n < 100) begin
      p = qbus_clk_o;
      @(negedge vm_clk_p);
      n++;
    end
    chk("clk_rise_seen", qbus_clk_o, 1);
  endtask

  initial begin
    logic [15:0]     a, d, d2;
    logic [NIRQ-1:0] irq_old, irq_new;
    logic            p;
    int              h;
    bit              ok;
    int              op;

    vm_rst = 1'b1;
    qbus_ad_i = '0; qbus_sync_i = 0; qbus_din_i = 0; qbus_dout_i = 0; qbus_wtbt_i = 0;
    qbus_iako_i = 0; qbus_sel_i = 0; qbus_init_i = 0;
    vm_aclo = 0; vm_dclo = 0; vm_irq = '0; sel_dat_i = '0;
    tick(4);
    chk("rst_rply", qbus_rply_o, 0);
    chk("rst_ad_oe", qbus_ad_oe, 0);
    chk("rst_ad_o", qbus_ad_o, 0);
    chk("rst_stb", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbi_stb_o}, 0);
    chk("rst_clk", qbus_clk_o, 0);
    chk("rst_berr", bus_err_o, 0);
    vm_rst = 1'b0;
    qbus_init_i = 1'b1;
    tick(SS + 1);
    chk("init_sync", vm_init_out, 1);
    qbus_init_i = 1'b0;
    tick(SS + 1);

    // Word read at 0o1000, slave acks after 3 cycles.
    addr_phase(16'o1000, 1'b0);
    do_read(16'o1000, 16'o123456, 3, 1'b1);
    end_cycle();

    // Byte write at 0o1001, high lane.
    addr_phase(16'o1001, 1'b1);
    do_write(16'o1001, 16'hAB00, 1'b1, 1'b0, 2);
    end_cycle();

    // DATIO at 0o2000.
    addr_phase(16'o2000, 1'b0);
    do_read(16'o2000, 16'h0005, 2, 1'b0);
    do_write(16'o2000, 16'h0006, 1'b0, 1'b0, 1);
    end_cycle();

    // Slave never answers: timeout, bus error, no RPLY.
    addr_phase(16'o3000, 1'b0);
    wb_q.push_back('{we: 1'b0, adr: 16'o3000, dat: 16'h0, sel: 2'b11, lat: 0, noack: 1'b1});
    exp_berr++;
    qbus_din_i = 1'b1;
    tick(SS + 1 + TMO + 4);
    chk("tmo_no_rply", qbus_rply_o, 0);
    chk("tmo_berr_seen", berr_cyc, exp_berr);
    qbus_din_i = 1'b0;
    tick(SS + 2);
    end_cycle();

    // Interrupt vector and addressless read.
    addrless_read(1'b1, 16'o000100);
    addrless_read(1'b0, 16'o140000);

    // Write while DCLO: RPLY without a Wishbone cycle.
    vm_dclo = 1'b1;
    addr_phase(16'o4000, 1'b0);
    do_write(16'o4000, 16'h1234, 1'b0, 1'b1, 1);
    end_cycle();
    vm_dclo = 1'b0;

    for (int i = 0; i < 16; i++) begin
      op = $urandom_range(0, 2);
      a  = 16'($urandom);
      d  = 16'($urandom);
      d2 = 16'($urandom);
      case (op)
        0: begin
          addr_phase(a, 1'b0);
          do_read(a, d, $urandom_range(1, 4), 1'b0);
        end
        1: begin
          p = 1'($urandom_range(0, 1));
          addr_phase(a, p);
          do_write(a, d, p, 1'b0, $urandom_range(1, 4));
        end
        default: begin
          addr_phase(a, 1'b0);
          do_read(a, d, $urandom_range(1, 4), 1'b0);
          do_write(a, d2, 1'b0, 1'b0, $urandom_range(1, 4));
        end
      endcase
      end_cycle();
    end

    tick(5);
    chk("wb_queue_drained", wb_q.size(), 0);
    chk("rply_queue_drained", rp_q.size(), 0);
    chk("iv_queue_drained", iv_q.size(), 0);
    chk("berr_total_cycles", berr_cyc, exp_berr);

    // CPU clock shape: high 4 of every 8 cycles.
    wait_clk_rise();
    h = 1;
    for (int k = 0; k < 7; k++) begin
      p = qbus_clk_o;
      @(negedge vm_clk_p);
      if (qbus_clk_o === 1'b1) h++;
    end
    chk("clk_high_cycles", h, 4);
    p = qbus_clk_o;
    @(negedge vm_clk_p);
    chk("clk_period_8", {p, qbus_clk_o}, 2'b01);

    // Request lines change on the CPU side only with the next rise.
    irq_old = qbus_irq_o;
    chk("irq_initial", irq_old, vm_irq);
    for (int r = 0; r < 2; r++) begin
      irq_new = NIRQ'($urandom) ^ irq_old;
      if (irq_new == irq_old) irq_new = ~irq_old;
      vm_irq  = irq_new;
      vm_aclo = ~vm_aclo;
      ok = 1'b1;
      for (int k = 0; k < 7; k++) begin
        @(negedge vm_clk_p);
        if (qbus_irq_o !== irq_old) ok = 1'b0;
      end
      chk("irq_held_until_rise", ok, 1);
      @(negedge vm_clk_p);
      chk("irq_clk_rise", qbus_clk_o, 1);
      chk("irq_updated", qbus_irq_o, irq_new);
      chk("aclo_updated", qbus_aclo_o, vm_aclo);
      irq_old = irq_new;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
